l3_instr_seq: RTL and testbench



---
 rtl/l3_instr_seq.sv | 186 ++++++++++++++++++
 tb/tb_l3_instr_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l3_instr_seq.sv
// -----------------------------------------------------------------------------
// l3_instr_seq
//
// Replays a stored program of 11-bit instructions onto the exec/instr
// interface of the Lab 3 control state machine (l3_SM). Each instruction is
// presented with exec high for its opcode's hold count (3 cycles for
// load/disp, 5 for ALU ops), followed by one exec-low GAP cycle. Opcode 101
// is a NOP: exec stays low and only the GAP cycle is spent.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   prog_we    program memory write enable (IDLE only)
//   prog_addr  program memory write address
//   prog_data  instruction word, [0:10] bit order as instr
//   prog_len   number of instructions to run, sampled on start
//   start      begin a run from address 0 (IDLE only)
//   step       single-step advance (only with L3_SEQ_STEP_EN)
//   exec       execute strobe to l3_SM
//   instr      opcode [0:2], reg_x [3:4], reg_y [5:6], imm [7:10]
//   pc         address of the instruction currently presented
//   busy       high while a run is in progress
//   done       one-cycle pulse at run completion
//
// Build option:
//   L3_SEQ_STEP_EN  adds the step port; the FSM waits in GAP after every
//                   non-final instruction until step is sampled high.
// -----------------------------------------------------------------------------
module l3_instr_seq #(
  parameter int ADDR_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [0:10]       prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
`ifdef L3_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              exec,
  output logic [0:10]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [0:2]      OP_NOP  = 3'b101;

  // Remaining exec-high cycles minus one for a non-NOP opcode.
  function automatic logic [2:0] hold_last(input logic [0:2] op);
    case (op)
      3'b000, 3'b100: hold_last = 3'd2;  // load, disp: 3 cycles
      default:        hold_last = 3'd4;  // mov, sub, add, subi, addi: 5 cycles
    endcase
  endfunction

  state_t            state;
  logic [0:10]       mem [PROG_DEPTH];
  logic [ADDR_W:0]   len_q;
  logic [2:0]        hold_cnt;

  logic [ADDR_W:0]   len_clip;
  logic [ADDR_W-1:0] pc_inc;
  logic              more;
  logic              advance;
  logic [0:10]       load_word;
  logic              load_nop;
  logic              addr_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    len_clip  = prog_len;
    if (prog_len > DEPTH_L) len_clip = DEPTH_L;
    pc_inc    = pc + ADDR_W'(1);
    more      = (({1'b0, pc} + (ADDR_W+1)'(1)) < len_q);
    // IDLE always starts from address 0; GAP fetches the next address.
    load_word = (state == S_IDLE) ? mem[0] : mem[pc_inc];
    load_nop  = (load_word[0:2] == OP_NOP);
    addr_ok   = ({1'b0, prog_addr} < DEPTH_L);
  end

`ifdef L3_SEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // NOTE: program memory has no reset; a stored program survives rst_n so a
  // run abandoned by reset can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && prog_we && addr_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: all state here is sequential, so it uses non-blocking assignments
  // only; every register sees values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      exec     <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      hold_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A simultaneous write wins over start.
          if (start && !prog_we) begin
            len_q <= len_clip;
            if (len_clip == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              pc       <= '0;
              instr    <= load_word;
              busy     <= 1'b1;
              hold_cnt <= hold_last(load_word[0:2]);
              if (load_nop) begin
                exec  <= 1'b0;
                state <= S_GAP;
              end else begin
                exec  <= 1'b1;
                state <= S_ISSUE;
              end
            end
          end
        end

        S_ISSUE: begin
          if (hold_cnt == '0) begin
            exec  <= 1'b0;
            state <= S_GAP;
          end else begin
            hold_cnt <= hold_cnt - 3'd1;
          end
        end

        S_GAP: begin
          if (!more) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (advance) begin
            pc       <= pc_inc;
            instr    <= load_word;
            hold_cnt <= hold_last(load_word[0:2]);
            if (load_nop) begin
              exec <= 1'b0;          // stay in GAP for one NOP cycle
            end else begin
              exec  <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          exec  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l3_instr_seq.sv
// -----------------------------------------------------------------------------
// tb_l3_instr_seq
//
// Directed bench for l3_instr_seq with default parameters (ADDR_W=4,
// PROG_DEPTH=16). Expected run lengths are hand-computed; per-cycle exec/pc/
// instr expectations come from a small reference of the hold-count rules.
// -----------------------------------------------------------------------------
module tb_l3_instr_seq;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [0:10] prog_data;
  logic [4:0]  prog_len;
  logic        start;
`ifdef L3_SEQ_STEP_EN
  logic        step;
`endif
  logic        exec;
  logic [0:10] instr;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] prog_m [16];

  l3_instr_seq #(.ADDR_W(4), .PROG_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
`ifdef L3_SEQ_STEP_EN
    .step      (step),
`endif
    .exec      (exec),
    .instr     (instr),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [10:0] w);
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_data = w;
    tick();
    prog_we   = 1'b0;
    prog_m[addr] = w;
  endtask

  function automatic int hold_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 3;
      3'b101:         return 0;
      default:        return 5;
    endcase
  endfunction

  // Runs len instructions, checking every cycle against the reference and
  // the cycle (counted from the start edge) at which done appears.
  // With poke set, start/prog_we are driven mid-run and must be ignored.
  task automatic run_prog(input string tag, input int len, input int exp_cycles, input bit poke);
    logic        e_exec [$];
    int          e_pc   [$];
    logic [10:0] e_ins  [$];
    int          n;
    int          cyc;
    n = (len > 16) ? 16 : len;
    for (int i = 0; i < n; i++) begin
      int h;
      h = hold_of(prog_m[i][10:8]);
      for (int c = 0; c < h; c++) begin
        e_exec.push_back(1'b1); e_pc.push_back(i); e_ins.push_back(prog_m[i]);
      end
      e_exec.push_back(1'b0); e_pc.push_back(i); e_ins.push_back(prog_m[i]);
    end

    prog_len = 5'(len);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'(n > 0));

    cyc = 0;
    while (cyc < 200) begin
      if (cyc < e_exec.size()) begin
        check({tag, "_exec"},  32'(exec),  32'(e_exec[cyc]));
        check({tag, "_pc"},    32'(pc),    32'(e_pc[cyc]));
        check({tag, "_instr"}, 32'(instr), 32'(e_ins[cyc]));
      end
      if (done) break;
      if (poke && cyc == 1) begin
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'h7FF; start = 1'b1;
      end
      if (poke && cyc == 3) begin
        prog_we = 1'b0; start = 1'b0;
      end
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycles));
    check({tag, "_exec_at_done"}, 32'(exec), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_exec_idle"}, 32'(exec), 32'd0);
    if (n > 0) check({tag, "_instr_kept"}, 32'(instr), 32'(prog_m[n-1]));
  endtask

  initial begin
    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
`ifdef L3_SEQ_STEP_EN
    step      = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_exec",  32'(exec),  32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc",    32'(pc),    32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Four loads: 4 x (3 + 1) = 16 cycles.
    write_word(0, 11'b00000000001);
    write_word(1, 11'b00001000010);
    write_word(2, 11'b00010000100);
    write_word(3, 11'b00011001000);
    run_prog("loads4", 4, 16, 1'b0);

    // Append mov/add/sub: 16 + 3 x 6 = 34 cycles.
    write_word(4, 11'b00110111000);
    write_word(5, 11'b01110011000);
    write_word(6, 11'b01011001000);
    run_prog("alu7", 7, 34, 1'b0);

    // load, NOP, load: 4 + 1 + 4 = 9 cycles.
    write_word(1, 11'b10100000000);
    run_prog("nop3", 3, 9, 1'b0);

    // Zero length: done in the cycle right after the start edge.
    run_prog("len0", 0, 0, 1'b0);

    // start together with prog_we: the write happens, start is ignored.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'b00000001111;
    start = 1'b1; prog_len = 5'd1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    prog_m[0] = 11'b00000001111;
    check("we_start_busy", 32'(busy), 32'd0);
    check("we_start_exec", 32'(exec), 32'd0);
    tick();
    check("we_start_done", 32'(done), 32'd0);
    run_prog("we_start_run", 1, 4, 1'b0);

    // start/prog_we while busy are ignored; word 0 must be unchanged after.
    run_prog("busy_poke", 1, 4, 1'b1);
    run_prog("busy_poke_verify", 1, 4, 1'b0);

    // Full memory with prog_len=31 clipped to 16:
    // words 0..6 = 4+1+4+4+6+6+6 = 31, words 7..15 disp = 9 x 4 = 36.
    for (int i = 7; i < 16; i++) write_word(i, 11'b10000000000 | 11'(i));
    run_prog("clip31", 31, 67, 1'b0);

    // Reset in the 2nd cycle of the mov at pc=4 (issue starts at cycle 13).
    prog_len = 5'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (14) tick();
    check("mid_pc_before", 32'(pc), 32'd4);
    check("mid_exec_before", 32'(exec), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_exec",  32'(exec),  32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_pc",    32'(pc),    32'd0);
    check("mid_rst_instr", 32'(instr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_prog("after_rst", 7, 31, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
